// File: rtl/demux4_deser.sv
// Serial-to-parallel deserializer: collects a 4-bit frame (bit 0 marked by sof) into q0..q3.
// Frames are aborted with an err pulse on restart (new sof) or after TIMEOUT idle cycles.
module demux4_deser #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sin,
    input  logic sin_valid,
    input  logic sof,
    output logic q0,
    output logic q1,
    output logic q2,
    output logic q3,
    output logic out_valid,
    output logic err,
    output logic busy
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

    logic [0:0] state_q, state_d;
    logic [1:0] count_q, count_d;
    logic [7:0] gap_q, gap_d, gap_inc;
    logic [2:0] shadow_q, shadow_d;
    logic [3:0] q_q, q_d;
    logic       out_valid_q, out_valid_d;
    logic       err_q, err_d;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        gap_d       = gap_q;
        shadow_d    = shadow_q;
        q_d         = q_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        // Saturate rather than wrap so a huge gap can never look short again.
        gap_inc     = (gap_q == 8'hff) ? gap_q : gap_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (sin_valid && sof) begin
                    shadow_d[0] = sin;
                    count_d     = 2'd1;
                    gap_d       = 8'd0;
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                if (sin_valid) begin
                    gap_d = 8'd0;
                    if (sof) begin
                        err_d       = 1'b1;
                        shadow_d[0] = sin;
                        count_d     = 2'd1;
                    end else if (count_q == 2'd3) begin
                        q_d         = {sin, shadow_q};
                        out_valid_d = 1'b1;
                        count_d     = 2'd0;
                        state_d     = IDLE;
                    end else begin
                        shadow_d[count_q] = sin;
                        count_d           = count_q + 2'd1;
                    end
                end else begin
                    gap_d = gap_inc;
                    if (gap_inc >= TimeoutVal) begin
                        err_d   = 1'b1;
                        count_d = 2'd0;
                        gap_d   = 8'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= 2'd0;
            gap_q       <= 8'd0;
            shadow_q    <= 3'd0;
            q_q         <= 4'd0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            shadow_q    <= shadow_d;
            q_q         <= q_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign q0        = q_q[0];
    assign q1        = q_q[1];
    assign q2        = q_q[2];
    assign q3        = q_q[3];
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign busy      = (state_q == COLLECT);

endmodule

// File: tb/tb_demux4_deser.sv
// Randomized and directed bench for demux4_deser against a queue-based frame model.
module tb_demux4_deser;

    localparam int unsigned TIMEOUT = 8;

    logic clk, rst_n, sin, sin_valid, sof;
    logic q0, q1, q2, q3, out_valid, err, busy;

    int checks = 0;
    int errors = 0;

    // Reference model: frame in progress as a queue of received bits.
    logic      m_bits[$];
    bit        m_in_frame;
    int        m_gap;
    logic [3:0] m_q;
    logic      m_ov, m_er;

    demux4_deser #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .out_valid(out_valid), .err(err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] obs();
        return {q3, q2, q1, q0, out_valid, err, busy};
    endfunction

    function automatic logic [6:0] expv();
        return {m_q, m_ov, m_er, logic'(m_in_frame)};
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_in_frame = 0;
        m_gap      = 0;
        m_q        = 4'd0;
        m_ov       = 1'b0;
        m_er       = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic b);
        m_ov = 1'b0;
        m_er = 1'b0;
        if (v && s) begin
            if (m_in_frame) m_er = 1'b1;
            m_bits.delete();
            m_bits.push_back(b);
            m_in_frame = 1;
            m_gap = 0;
        end else if (v && m_in_frame) begin
            m_bits.push_back(b);
            m_gap = 0;
            if (m_bits.size() == 4) begin
                m_q = {m_bits[3], m_bits[2], m_bits[1], m_bits[0]};
                m_ov = 1'b1;
                m_in_frame = 0;
                m_bits.delete();
            end
        end else if (!v && m_in_frame) begin
            m_gap++;
            if (m_gap >= int'(TIMEOUT)) begin
                m_er = 1'b1;
                m_in_frame = 0;
                m_bits.delete();
            end
        end
    endtask

    // Called 1 time unit after a rising edge; drives inputs and advances one cycle.
    task automatic drive(input logic v, input logic s, input logic b);
        sin_valid = v;
        sof       = s;
        sin       = b;
        @(posedge clk);
        #1;
        model_step(v, s, b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0;
        model_reset();
        #3;
        checks++;
        if (obs() !== 7'd0) begin
            errors++; $display("FAIL reset_initial: got %b want %b", obs(), 7'd0);
        end
        sin_valid = 1'b1; sof = 1'b1; sin = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs() !== 7'd0) begin
            errors++; $display("FAIL reset_held: got %b want %b", obs(), 7'd0);
        end
        sin_valid = 1'b0; sof = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        bits = 4'b1101;  // bit0 first: 1,0,1,1
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, bits[i]);
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL basic cyc%0d: got %b want %b", i, obs(), expv());
            end
        end
        checks++;
        if ({q3, q2, q1, q0, out_valid, busy} !== 6'b1101_1_0) begin
            errors++;
            $display("FAIL basic_frame: got %b want %b", {q3, q2, q1, q0, out_valid, busy}, 6'b110110);
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || obs() !== expv()) begin
            errors++; $display("FAIL basic_pulse: got %b want %b", obs(), expv());
        end
    endtask

    task automatic test_gap();
        logic v[7] = '{1, 1, 0, 0, 0, 1, 1};
        logic b[7] = '{0, 1, 0, 0, 0, 1, 0};
        for (int i = 0; i < 7; i++) begin
            drive(v[i], i == 0, b[i]);
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL gap cyc%0d: got %b want %b", i, obs(), expv());
            end
        end
        checks++;
        if ({q3, q2, q1, q0, out_valid, err} !== 6'b0110_1_0) begin
            errors++;
            $display("FAIL gap_frame: got %b want %b", {q3, q2, q1, q0, out_valid, err}, 6'b011010);
        end
    endtask

    task automatic test_timeout();
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= int'(TIMEOUT); i++) begin
            drive(1'b0, 1'b0, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL timeout gap%0d: got %b want %b", i, obs(), expv());
            end
        end
        checks++;
        if ({q3, q2, q1, q0, out_valid, err, busy} !== 7'b0110_0_1_0) begin
            errors++;
            $display("FAIL timeout_err: got %b want %b", obs(), 7'b0110010);
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse: got err=%b want 0", err);
        end
    endtask

    task automatic test_restart();
        logic s[6] = '{1, 0, 1, 0, 0, 0};
        logic b[6] = '{1, 1, 0, 0, 0, 1};
        int   nerr = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, s[i], b[i]);
            if (err === 1'b1) nerr++;
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL restart cyc%0d: got %b want %b", i, obs(), expv());
            end
        end
        checks++;
        if ({q3, q2, q1, q0, out_valid} !== 5'b1000_1 || nerr != 1) begin
            errors++;
            $display("FAIL restart_frame: got q=%b ov=%b errs=%0d want q=1000 ov=1 errs=1",
                     {q3, q2, q1, q0}, out_valid, nerr);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits = 8'b0111_1000;  // frame A 0,0,0,1 then frame B 1,1,1,0
        int ov_cyc[$];
        int nerr = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i % 4) == 0, bits[i]);
            if (out_valid === 1'b1) ov_cyc.push_back(i);
            if (err === 1'b1) nerr++;
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL b2b cyc%0d: got %b want %b", i, obs(), expv());
            end
        end
        checks++;
        if (ov_cyc.size() != 2 || nerr != 0 || {q3, q2, q1, q0} !== 4'b0111
            || (ov_cyc.size() == 2 && ov_cyc[1] - ov_cyc[0] != 4)) begin
            errors++;
            $display("FAIL b2b_summary: got pulses=%0d errs=%0d q=%b want pulses=2 apart 4 errs=0 q=0111",
                     ov_cyc.size(), nerr, {q3, q2, q1, q0});
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] bits = 4'b1001;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        sin_valid = 1'b1; sof = 1'b0; sin = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs() !== 7'd0) begin
            errors++; $display("FAIL async_reset: got %b want %b", obs(), 7'd0);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);  // stray bit 2 after reset must be ignored
        checks++;
        if (obs() !== expv() || busy !== 1'b0) begin
            errors++; $display("FAIL async_stray: got %b want %b", obs(), expv());
        end
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, bits[i]);
        checks++;
        if ({q3, q2, q1, q0, out_valid, err} !== 6'b1001_1_0) begin
            errors++;
            $display("FAIL async_frame: got %b want %b", {q3, q2, q1, q0, out_valid, err}, 6'b100110);
        end
    endtask

    task automatic test_random();
        logic v, s, b;
        int   p;
        for (int i = 0; i < 600; i++) begin
            p = int'($urandom_range(0, 99));
            if (p >= 96) begin
                repeat ($urandom_range(5, 10)) begin
                    drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                    checks++;
                    if (obs() !== expv()) begin
                        errors++; $display("FAIL random_gap it%0d: got %b want %b", i, obs(), expv());
                    end
                end
            end else begin
                v = (p < 65);
                s = v && ($urandom_range(0, 99) < 22);
                b = 1'($urandom_range(0, 1));
                drive(v, s, b);
                checks++;
                if (obs() !== expv()) begin
                    errors++; $display("FAIL random it%0d: got %b want %b", i, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_timeout();
        test_restart();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
